// File: rtl/clz_defs.sv
// Shared constants for the count-leading-zeros/ones unit.
// Holds operand/count widths and the FSM state encoding.
package clz_defs;

    localparam int WIDTH = 32;
    localparam int CW    = 6;
    localparam int KW    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/clz_step.sv
// One binary-search step: tests whether the top 2^k bits equal fill.
// Ports: v, k, fill in; hit, v_next (v shifted by 2^k on hit) out.
module clz_step
    import clz_defs::*;
(
    input  logic [WIDTH-1:0] v,
    input  logic [KW-1:0]    k,
    input  logic             fill,
    output logic             hit,
    output logic [WIDTH-1:0] v_next
);

    logic [7:0]       n;
    logic [WIDTH-1:0] all_ones;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] diff;

    always_comb begin
        n        = 8'd1 << k;
        all_ones = '1;
        // Top n bits set; n >= WIDTH yields an all-ones mask.
        mask     = ~(all_ones >> n);
        diff     = v ^ {WIDTH{fill}};
        hit      = ((diff & mask) == '0);
        v_next   = hit ? (v << n) : v;
    end

endmodule

// File: rtl/clz_unit.sv
// Multi-cycle CLZ/CLO unit: 5-step binary search plus one fix-up step.
// Ports: clk, reset_n, start, a, ones, flush in; busy, done, count, norm out.
module clz_unit
    import clz_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic             ones,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] norm
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] v;
    logic             fill;
    logic [CW-1:0]    acc;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_sel;
    logic             hit;
    logic [WIDTH-1:0] v_next;
    logic [CW-1:0]    step_n;
    logic             accept;

    // FIX reuses the step logic as a single-bit test.
    assign k_sel  = (state == FIX) ? '0 : k;
    assign accept = start && !flush;

    clz_step u_step (
        .v      (v),
        .k      (k_sel),
        .fill   (fill),
        .hit    (hit),
        .v_next (v_next)
    );

    assign step_n = hit ? (CW'(1) << k_sel) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: begin
                state_n = accept ? SEARCH : IDLE;
            end
            SEARCH: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (k == '0) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                state_n = flush ? IDLE : DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v     <= '0;
            fill  <= 1'b0;
            acc   <= '0;
            k     <= '0;
            count <= '0;
            norm  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        v    <= a;
                        fill <= ones;
                        acc  <= '0;
                        k    <= KW'(4);
                    end
                end
                SEARCH: begin
                    if (!flush) begin
                        v   <= v_next;
                        acc <= acc + step_n;
                        if (k != '0) begin
                            k <= k - KW'(1);
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        v     <= v_next;
                        acc   <= acc + step_n;
                        count <= acc + step_n;
                        norm  <= v_next;
                    end
                end
            endcase
        end
    end

    assign busy = (state == SEARCH) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_clz_unit.sv
// Self-checking bench for clz_unit against a bit-scan reference model.
// Drives inputs and samples outputs on the falling clock edge.
module tb_clz_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic        ones;
    logic        flush;
    logic        busy;
    logic        done;
    logic [5:0]  count;
    logic [31:0] norm;

    int passed;
    int total;

    clz_unit #(.WIDTH(32), .CW(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .ones    (ones),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .norm    (norm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_count(input logic [31:0] x, input logic o);
        int c;
        c = 0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i] != o) break;
            c++;
        end
        return c;
    endfunction

    function automatic logic [31:0] ref_norm(input logic [31:0] x, input logic o);
        int c;
        c = ref_count(x, o);
        if (c >= 32) return 32'h0;
        return x << c;
    endfunction

    // Issues start at the current falling edge and waits for done.
    task automatic do_op(input logic [31:0] av, input logic ov,
                         output logic [5:0] cnt, output logic [31:0] nrm,
                         output int lat, output int bcnt, output logic seen);
        a     = av;
        ones  = ov;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        seen = done;
        cnt  = count;
        nrm  = norm;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        a       = '0;
        ones    = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_flags busy/done=%b want 00", {busy, done});
        else passed++;
        total++;
        if (count !== 6'd0 || norm !== 32'h0)
            $display("FAIL reset_out count=%0d norm=%h want 0/0", count, norm);
        else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency;
        logic [5:0] c; logic [31:0] n; int lat, bc; logic s;
        do_op(32'h0001_0000, 1'b0, c, n, lat, bc, s);
        total++;
        if (!s || lat !== 7) $display("FAIL latency got=%0d seen=%b want 7", lat, s);
        else passed++;
        total++;
        if (bc !== 6) $display("FAIL busy_cycles got=%0d want 6", bc);
        else passed++;
        total++;
        if (c !== 6'd15 || n !== 32'h8000_0000)
            $display("FAIL clz_10000 got=%0d/%h want 15/80000000", c, n);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL busy_in_done got=%b want 0", busy);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL done_pulse got=%b want 0", done);
        else passed++;
    endtask

    task automatic test_directed;
        logic [31:0] va [5];
        logic        vo [5];
        logic [5:0] c; logic [31:0] n; int lat, bc; logic s;
        va = '{32'h0, 32'h8000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        vo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vo[i], c, n, lat, bc, s);
            total++;
            if (!s || c !== 6'(ref_count(va[i], vo[i])) || n !== ref_norm(va[i], vo[i]))
                $display("FAIL directed_%0d got=%0d/%h want %0d/%h", i, c, n,
                         ref_count(va[i], vo[i]), ref_norm(va[i], vo[i]));
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [31:0] x; logic o;
        logic [5:0] c; logic [31:0] n; int lat, bc; logic s;
        for (int i = 0; i < 40; i++) begin
            x = $urandom();
            x = x >> $urandom_range(0, 32);
            o = 1'($urandom_range(0, 1));
            if (o) x = ~x;
            do_op(x, o, c, n, lat, bc, s);
            total++;
            if (!s || lat !== 7 || c !== 6'(ref_count(x, o)) || n !== ref_norm(x, o))
                $display("FAIL random_%0d a=%h ones=%b got=%0d/%h lat=%0d want %0d/%h",
                         i, x, o, c, n, lat, ref_count(x, o), ref_norm(x, o));
            else passed++;
            // Odd iterations issue back-to-back from the done cycle.
            if (i % 2 == 0) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] c; logic [31:0] n; int lat, bc; logic s;
        a     = 32'h1;
        ones  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a     = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 4;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (!done || lat !== 7 || count !== 6'd31 || norm !== 32'h8000_0000)
            $display("FAIL ignored_start got=%0d/%h lat=%0d want 31/80000000 lat 7",
                     count, norm, lat);
        else passed++;
        do_op(32'h0, 1'b0, c, n, lat, bc, s);
        total++;
        if (!s || lat !== 7 || c !== 6'd32 || n !== 32'h0)
            $display("FAIL back_to_back got=%0d/%h lat=%0d want 32/0 lat 7", c, n, lat);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_flush;
        logic [5:0] c; logic [31:0] n; int lat, bc; logic s;
        int ndone, nbusy;
        do_op(32'h0001_0000, 1'b0, c, n, lat, bc, s);
        @(negedge clk);
        a     = 32'hFFFF_FFFF;
        ones  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL flush_abort busy/done=%b want 00", {busy, done});
        else passed++;
        ndone = 0;
        repeat (10) begin
            if (done) ndone++;
            @(negedge clk);
        end
        total++;
        if (ndone !== 0 || count !== 6'd15 || norm !== 32'h8000_0000)
            $display("FAIL flush_hold done=%0d got=%0d/%h want 0 15/80000000",
                     ndone, count, norm);
        else passed++;
        a     = 32'h0;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        ndone = 0;
        nbusy = 0;
        repeat (10) begin
            if (done) ndone++;
            if (busy) nbusy++;
            @(negedge clk);
        end
        total++;
        if (ndone !== 0 || nbusy !== 0 || count !== 6'd15)
            $display("FAIL flush_blocks_start done=%0d busy=%0d count=%0d want 0 0 15",
                     ndone, nbusy, count);
        else passed++;
    endtask

    task automatic test_reset_in_fix;
        logic [5:0] c; logic [31:0] n; int lat, bc; logic s;
        int ndone;
        a     = 32'h1234_5678;
        ones  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL fix_busy got=%b want 1", busy);
        else passed++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== 6'd0 || norm !== 32'h0)
            $display("FAIL reset_fix busy=%b done=%b got=%0d/%h want 0 0 0/0",
                     busy, done, count, norm);
        else passed++;
        ndone = 0;
        repeat (8) begin
            if (done) ndone++;
            @(negedge clk);
        end
        total++;
        if (ndone !== 0) $display("FAIL reset_no_done got=%0d want 0", ndone);
        else passed++;
        do_op(32'h0000_FFFF, 1'b0, c, n, lat, bc, s);
        total++;
        if (!s || c !== 6'd16 || n !== 32'hFFFF_0000)
            $display("FAIL after_reset got=%0d/%h want 16/ffff0000", c, n);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset;
        test_latency;
        test_directed;
        test_random;
        test_back_to_back;
        test_flush;
        test_reset_in_fix;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/clz_unit.md
# clz_unit

Multi-cycle count-leading-zeros/ones unit for the MIPS datapath; it implements CLZ and CLO and returns the matching normalised operand. It is the inverse of the ALU barrel shift. The shifter takes a value and an amount and produces a shifted value. This block takes a value and derives the left-shift amount that left-justifies it. It sits beside the ALU, raises `busy` to stall the pipeline, and uses a 5-step binary search plus one fix-up step.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported.
- `CW`, 6: count width, equal to log2(WIDTH)+1.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only when the unit is idle (state IDLE or DONE).
- `a`  in  32  operand, captured with `start`.
- `ones`  in  1  operation select, captured with `start`: 0 = CLZ (fill bit 0), 1 = CLO (fill bit 1).
- `flush`  in  1  abandon the current operation.
- `busy`  out  1  high in SEARCH and FIX.
- `done`  out  1  one-cycle pulse; `count` and `norm` are valid while it is high.
- `count`  out  6  number of leading fill bits, range 0..32.
- `norm`  out  32  `a << count`, zero-filled; equals 0 when `count` = 32.

## Operation
- **States:** IDLE, SEARCH, FIX, DONE.
- **IDLE/DONE, `start`=1:** latch `a` into the working register `v`, latch `ones` into `fill`. Clear `acc`, set `k`=4, go to SEARCH.
- **IDLE/DONE, `start`=0:** DONE goes to IDLE; IDLE stays in IDLE.
- **SEARCH, one step per cycle:** let `n` = 2^k.
  - If the top `n` bits of `v` all equal `fill`: `v` <= `v << n` and `acc` <= `acc + n`.
  - `k` counts down 4,3,2,1,0. After the `k`=0 step, go to FIX.
- **FIX:**
  - If `v[31]` == `fill`: `acc` <= `acc + 1` and `v` <= `v << 1`. This case arises only for an all-fill operand, giving `acc` = 32 and `v` = 0.
  - Then `count` <= `acc`, `norm` <= `v`, go to DONE.
- **Width rules:**
  - `acc` is 6 bits and never exceeds 32.
  - All shifts are logical left with zero fill, including for CLO.
- **`count`/`norm` hold:** both keep their value until the next FIX completes. They are not cleared by `start`, `flush` or leaving DONE.
- **`flush`:** when high in SEARCH or FIX, go to IDLE next edge with no `done` and no output update. `flush` has priority over `start`. It has no effect in IDLE/DONE except to block `start`.
- **`start` while `busy`:** ignored; it is not queued.
- **`reset_n` low:**
  - Mid-operation: next edge forces IDLE and discards the operation.
  - Output values: `busy`=0, `done`=0, `count`=0, `norm`=0; internal `v`, `acc` and `k` are cleared.

## Timing
- **Latency:** `start` sampled at edge E → SEARCH steps at edges E+1..E+5 → FIX at E+6 → `done`=1 for exactly the cycle after E+6.
- **`busy`:** high from after E through the cycle ending at E+6. It is low in the `done` cycle.
- **Back-to-back:** a `start` presented in the `done` cycle is accepted. Sustained throughput is one result per 7 cycles.
- **Outputs:** all are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared constants package `clz_defs`:**
  - 2-bit state encoding: IDLE=0, SEARCH=1, FIX=2, DONE=3.
  - `WIDTH`, `CW`, and the step-index width of 3 bits.
- **Sub-module `clz_step` (combinational):**
  - Inputs: `v[31:0]`, `k[2:0]`, `fill`.
  - Outputs: `hit`, `v_next[31:0]`.
  - `hit` = top 2^k bits of `v` all equal `fill`; `v_next` = `hit` ? `v << 2^k` : `v`.
  - It is reused for the FIX step with `k`=0.
- **`clz_unit` owns:** the FSM, the `acc`/`k` counters and the output registers.

## Test plan
- CLZ, `a`=0x00010000 → `done` exactly 7 cycles after the `start` edge, `count`=15, `norm`=0x80000000, `busy` high for 6 cycles.
- CLZ, `a`=0x00000000 → `count`=32, `norm`=0. CLZ, `a`=0x80000000 → `count`=0, `norm`=0x80000000.
- CLO, `a`=0xFFFFFFF0 → `count`=28, `norm`=0x00000000. CLO, `a`=0xFFFFFFFF → `count`=32, `norm`=0.
- CLZ, `a`=0x1; `start` re-asserted with `a`=0 in cycle 3 → second request ignored, `count`=31, `norm`=0x80000000. Then `start` in the `done` cycle with `a`=0 → `count`=32 seven cycles later.
- Prior result `count`=15. `flush` at SEARCH step 2 → no `done`, `busy` low next cycle, `count`/`norm` still hold 15/0x80000000. `flush` and `start` together in IDLE → no operation starts.
- `reset_n` low for one cycle during FIX → IDLE with all outputs 0 and no `done`. A fresh CLZ of 0x0000FFFF then returns `count`=16, `norm`=0xFFFF0000.
